tinyalu_param: RTL and testbench

Parametrised next-generation tiny ALU. Operands are WIDTH bits wide and multiply latency is configurable. Adds subtract, multiply-accumulate and accumulator-clear operations. Uses the same start/done handshake as the existing tinyalu, so current bench drivers run unchanged at WIDTH=8.

---
 rtl/tinyalu_param.sv | 135 +++++++++++++
 tb/tb_tinyalu_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU: WIDTH-bit unsigned operands, 2*WIDTH-bit result, start/done handshake,
// configurable multiply latency, and a sticky-overflow multiply-accumulate register.
module tinyalu_param #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ovf
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_MAC = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        MULT  = 2'd2
    } state_e;

    state_e            state;
    op_e               op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     acc;
    logic              armed;

    logic [RW-1:0]     a_ext;
    logic [RW-1:0]     b_ext;
    logic [RW-1:0]     prod;
    logic [RW:0]       mac_sum;
    logic [RW-1:0]     alu_res;

    // Datapath works only on captured operands, so input changes while busy are ignored.
    always_comb begin
        a_ext   = RW'(a_q);
        b_ext   = RW'(b_q);
        prod    = a_ext * b_ext;
        mac_sum = {1'b0, acc} + {1'b0, prod};
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_SUB:  alu_res = a_ext - b_ext;
            default: alu_res = '0;
        endcase
    end

    // Control FSM; armed blocks re-execution while start stays high after done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_q   <= OP_NOP;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            acc    <= '0;
            armed  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!start) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && armed && (op != 3'b000)) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= op_e'(op);
                        if ((op == 3'b100) || (op == 3'b110)) begin
                            state <= MULT;
                            cnt   <= CW'(MUL_LAT - 1);
                        end else begin
                            state <= EXEC1;
                        end
                    end
                end
                EXEC1: begin
                    done  <= 1'b1;
                    armed <= ~start;
                    state <= IDLE;
                    if (op_q == OP_CLR) begin
                        acc    <= '0;
                        ovf    <= 1'b0;
                        result <= '0;
                    end else begin
                        result <= alu_res;
                    end
                end
                MULT: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        armed <= ~start;
                        state <= IDLE;
                        if (op_q == OP_MAC) begin
                            acc    <= mac_sum[RW-1:0];
                            result <= mac_sum[RW-1:0];
                            if (mac_sum[RW]) begin
                                ovf <= 1'b1;
                            end
                        end else begin
                            result <= prod;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tinyalu_param.sv
// Scoreboard bench for tinyalu_param (WIDTH=8, MUL_LAT=3): directed commands push expected
// result/ovf/done-cycle; a negedge monitor pops and checks on every done pulse.
module tb_tinyalu_param;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_res_q [$];
    logic        exp_ovf_q [$];
    int          exp_cyc_q [$];

    tinyalu_param #(.WIDTH(8), .MUL_LAT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            total++;
            if (exp_res_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: cycle=%0d result=%h, required no done", cyc, result);
            end else begin
                logic [15:0] er;
                logic        eo;
                int          ec;
                er = exp_res_q.pop_front();
                eo = exp_ovf_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (result !== er) begin
                    bad++;
                    $display("FAIL result: got %h, required %h", result, er);
                end
                total++;
                if (ovf !== eo) begin
                    bad++;
                    $display("FAIL ovf: got %b, required %b", ovf, eo);
                end
                total++;
                if (cyc != ec) begin
                    bad++;
                    $display("FAIL latency: done at cycle %0d, required %0d", cyc, ec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Issue one command, hold start until done (plus hold cycles), optionally scramble inputs mid-op.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                           input logic [15:0] er, input logic eo, input int lat,
                           input int hold, input bit scramble);
        bit got;
        @(posedge clk);
        #1;
        A = a; B = b; op = o; start = 1'b1;
        exp_res_q.push_back(er);
        exp_ovf_q.push_back(eo);
        exp_cyc_q.push_back(cyc + 1 + lat);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            if (k == 1 && scramble) begin
                A = ~a; B = 8'h01; op = 3'b001;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: done=%b, required done within 40 cycles", done);
        end
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        A = '0; B = '0; op = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done",   16'(done),   16'h0);
        check("reset_result", result,      16'h0000);
        check("reset_ovf",    16'(ovf),    16'h0);
        reset_n = 1'b1;

        run_cmd(8'd255, 8'd255, 3'b001, 16'h01FE, 1'b0, 1, 0, 1'b0);
        run_cmd(8'hF0,  8'h3C,  3'b010, 16'h0030, 1'b0, 1, 0, 1'b0);
        run_cmd(8'hA5,  8'h0F,  3'b011, 16'h00AA, 1'b0, 1, 0, 1'b0);
        run_cmd(8'd255, 8'd255, 3'b100, 16'hFE01, 1'b0, 3, 0, 1'b1);
        run_cmd(8'd3,   8'd5,   3'b101, 16'hFFFE, 1'b0, 1, 0, 1'b0);
        run_cmd(8'd0,   8'd0,   3'b111, 16'h0000, 1'b0, 1, 0, 1'b0);
        run_cmd(8'd200, 8'd200, 3'b110, 16'h9C40, 1'b0, 3, 0, 1'b0);
        run_cmd(8'd200, 8'd200, 3'b110, 16'h3880, 1'b1, 3, 0, 1'b0);
        // start held 5 cycles past done: single pulse, ovf stays sticky across other ops
        run_cmd(8'd1,   8'd2,   3'b001, 16'h0003, 1'b1, 1, 5, 1'b0);
        run_cmd(8'd0,   8'd0,   3'b111, 16'h0000, 1'b0, 1, 0, 1'b0);

        // no_op: no done pulse, result unchanged
        @(posedge clk);
        #1;
        A = 8'd7; B = 8'd9; op = 3'b000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("noop_result", result, 16'h0000);

        // set ovf again, then reset in the middle of a mul
        run_cmd(8'd200, 8'd200, 3'b110, 16'h9C40, 1'b0, 3, 0, 1'b0);
        run_cmd(8'd200, 8'd200, 3'b110, 16'h3880, 1'b1, 3, 0, 1'b0);
        @(posedge clk);
        #1;
        A = 8'd9; B = 8'd9; op = 3'b100; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        check("abort_done",   16'(done), 16'h0);
        check("abort_result", result,    16'h0000);
        check("abort_ovf",    16'(ovf),  16'h0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 16'(done), 16'h0);
        reset_n = 1'b1;
        run_cmd(8'd1, 8'd1, 3'b001, 16'h0002, 1'b0, 1, 0, 1'b0);

        repeat (4) @(negedge clk);
        check("pending_expectations", 16'(exp_res_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
